// File: rtl/local_mem_cfg_pkg.sv
// Local-memory bus types and limits shared by the burst splitter and its helpers.
package local_mem_cfg_pkg;

   localparam int unsigned LOCAL_MEM_ADDR_WIDTH      = 32;
   localparam int unsigned LOCAL_MEM_DATA_WIDTH      = 64;
   localparam int unsigned LOCAL_MEM_BURST_CNT_WIDTH = 7;
   localparam int unsigned LOCAL_MEM_BYTE_MASK_WIDTH = LOCAL_MEM_DATA_WIDTH / 8;
   localparam int unsigned LOCAL_MEM_MAX_BURST       = 2 ** (LOCAL_MEM_BURST_CNT_WIDTH - 1);

   typedef logic [LOCAL_MEM_ADDR_WIDTH-1:0]      t_local_mem_addr;
   typedef logic [LOCAL_MEM_DATA_WIDTH-1:0]      t_local_mem_data;
   typedef logic [LOCAL_MEM_BURST_CNT_WIDTH-1:0] t_local_mem_burst_cnt;
   typedef logic [LOCAL_MEM_BYTE_MASK_WIDTH-1:0] t_local_mem_byte_mask;

   // Avalon command payload: start address plus beat count.
   typedef struct packed {
      t_local_mem_addr      addr;
      t_local_mem_burst_cnt burstcount;
   } t_local_mem_cmd;

endpackage

// File: rtl/local_mem_burst_len.sv
// Length of the next burst: the remaining lines, clipped so the burst stays
// inside one MAX_BURST-aligned window.
module local_mem_burst_len
   import local_mem_cfg_pkg::*;
#(
   parameter int unsigned MAX_BURST = LOCAL_MEM_MAX_BURST,
   parameter int unsigned LEN_WIDTH = 16
) (
   input  t_local_mem_addr       addr,
   input  logic [LEN_WIDTH-1:0]  remaining,
   output t_local_mem_burst_cnt  burst_len_c
);

   localparam int unsigned CALC_W = 32;

   logic [CALC_W-1:0] room;
   logic [CALC_W-1:0] rem_ext;

   always_comb begin
      room        = CALC_W'(MAX_BURST) - (CALC_W'(addr) & CALC_W'(MAX_BURST - 1));
      rem_ext     = CALC_W'(remaining);
      burst_len_c = (rem_ext < room) ? t_local_mem_burst_cnt'(rem_ext)
                                     : t_local_mem_burst_cnt'(room);
   end

endmodule

// File: rtl/local_mem_burst_splitter.sv
// Splits line-granular read/write requests into boundary-aligned Avalon bursts
// and returns read data with a single register stage.
module local_mem_burst_splitter
   import local_mem_cfg_pkg::*;
#(
   parameter int unsigned MAX_BURST = LOCAL_MEM_MAX_BURST,
   parameter int unsigned LEN_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,

   input  logic                  req_valid,
   input  logic                  req_rw,
   input  t_local_mem_addr       req_addr,
   input  logic [LEN_WIDTH-1:0]  req_len,
   output logic                  req_ready,

   input  logic                  wr_valid,
   input  t_local_mem_data       wr_data,
   input  t_local_mem_byte_mask  wr_byteen,
   output logic                  wr_ready,

   output logic                  rd_valid,
   output t_local_mem_data       rd_data,

   output t_local_mem_addr       avs_address,
   output t_local_mem_burst_cnt  avs_burstcount,
   output logic                  avs_read,
   output logic                  avs_write,
   output t_local_mem_data       avs_writedata,
   output t_local_mem_byte_mask  avs_byteenable,
   input  logic                  avs_waitrequest,
   input  t_local_mem_data       avs_readdata,
   input  logic                  avs_readdatavalid,

   output logic                  busy
);

   localparam int unsigned OUT_WIDTH = LEN_WIDTH + 1;

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] RD_CMD  = 2'd1;
   localparam logic [1:0] WR_BEAT = 2'd2;

   logic [1:0]            state_q, state_d;
   t_local_mem_cmd        cmd_q, cmd_d;
   t_local_mem_addr       addr_d;
   logic [LEN_WIDTH-1:0]  rem_q, rem_d;
   t_local_mem_burst_cnt  beat_q, beat_d;
   t_local_mem_burst_cnt  next_len_c;
   logic [OUT_WIDTH-1:0]  outst_q, outst_d;
   logic                  issue_c;
   logic                  busy_q;
   logic                  rd_valid_q;
   t_local_mem_data       rd_data_q;

   // Burst length is precomputed from the next address/remaining so the
   // registered burstcount is valid on the first command cycle.
   local_mem_burst_len #(
      .MAX_BURST (MAX_BURST),
      .LEN_WIDTH (LEN_WIDTH)
   ) u_burst_len (
      .addr        (addr_d),
      .remaining   (rem_d),
      .burst_len_c (next_len_c)
   );

   assign cmd_d = '{addr: addr_d, burstcount: next_len_c};

   always_comb begin
      state_d = state_q;
      addr_d  = cmd_q.addr;
      rem_d   = rem_q;
      beat_d  = beat_q;
      issue_c = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               addr_d = req_addr;
               rem_d  = req_len;
               beat_d = '0;
               if (req_len != '0) state_d = req_rw ? WR_BEAT : RD_CMD;
            end
         end
         RD_CMD: begin
            if (!avs_waitrequest) begin
               issue_c = 1'b1;
               addr_d  = cmd_q.addr + t_local_mem_addr'(cmd_q.burstcount);
               rem_d   = rem_q - LEN_WIDTH'(cmd_q.burstcount);
               if (rem_d == '0) state_d = IDLE;
            end
         end
         WR_BEAT: begin
            if (wr_valid && !avs_waitrequest) begin
               if ((beat_q + t_local_mem_burst_cnt'(1)) == cmd_q.burstcount) begin
                  beat_d = '0;
                  addr_d = cmd_q.addr + t_local_mem_addr'(cmd_q.burstcount);
                  rem_d  = rem_q - LEN_WIDTH'(cmd_q.burstcount);
                  if (rem_d == '0) state_d = IDLE;
               end else begin
                  beat_d = beat_q + t_local_mem_burst_cnt'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Issue and return may coincide; both adjust the count in one step.
   always_comb begin
      outst_d = outst_q;
      if (issue_c) outst_d = outst_d + OUT_WIDTH'(cmd_q.burstcount);
      if (avs_readdatavalid) outst_d = outst_d - OUT_WIDTH'(1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         cmd_q      <= '0;
         rem_q      <= '0;
         beat_q     <= '0;
         outst_q    <= '0;
         busy_q     <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         cmd_q      <= cmd_d;
         rem_q      <= rem_d;
         beat_q     <= beat_d;
         outst_q    <= outst_d;
         busy_q     <= (state_d != IDLE) || (outst_d != '0);
         rd_valid_q <= avs_readdatavalid;
         rd_data_q  <= avs_readdata;
      end
   end

   assign req_ready      = (state_q == IDLE);
   assign avs_read       = (state_q == RD_CMD);
   assign avs_write      = (state_q == WR_BEAT) && wr_valid;
   assign wr_ready       = (state_q == WR_BEAT) && !avs_waitrequest;
   assign avs_writedata  = wr_data;
   assign avs_byteenable = wr_byteen;
   assign avs_address    = cmd_q.addr;
   assign avs_burstcount = cmd_q.burstcount;
   assign rd_valid       = rd_valid_q;
   assign rd_data        = rd_data_q;
   assign busy           = busy_q;

endmodule

// File: tb/tb_local_mem_burst_splitter.sv
// Randomized bench for local_mem_burst_splitter with an Avalon memory model
// and a burst-list reference derived from address/length arithmetic.
`timescale 1ns/1ps
module tb_local_mem_burst_splitter;
   import local_mem_cfg_pkg::*;

   localparam int unsigned MB    = 4;
   localparam int unsigned LW    = 16;
   localparam int          LIMIT = 3000;

   typedef struct {
      t_local_mem_addr      addr;
      t_local_mem_burst_cnt bc;
   } cmd_t;

   typedef struct {
      t_local_mem_data      data;
      t_local_mem_byte_mask be;
   } wbeat_t;

   logic                 clk, reset_n;
   logic                 req_valid, req_rw, req_ready;
   t_local_mem_addr      req_addr;
   logic [LW-1:0]        req_len;
   logic                 wr_valid, wr_ready;
   t_local_mem_data      wr_data;
   t_local_mem_byte_mask wr_byteen;
   logic                 rd_valid;
   t_local_mem_data      rd_data;
   t_local_mem_addr      avs_address;
   t_local_mem_burst_cnt avs_burstcount;
   logic                 avs_read, avs_write;
   t_local_mem_data      avs_writedata;
   t_local_mem_byte_mask avs_byteenable;
   logic                 avs_waitrequest;
   t_local_mem_data      avs_readdata;
   logic                 avs_readdatavalid;
   logic                 busy;

   local_mem_burst_splitter #(.MAX_BURST(MB), .LEN_WIDTH(LW)) dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .req_valid         (req_valid),
      .req_rw            (req_rw),
      .req_addr          (req_addr),
      .req_len           (req_len),
      .req_ready         (req_ready),
      .wr_valid          (wr_valid),
      .wr_data           (wr_data),
      .wr_byteen         (wr_byteen),
      .wr_ready          (wr_ready),
      .rd_valid          (rd_valid),
      .rd_data           (rd_data),
      .avs_address       (avs_address),
      .avs_burstcount    (avs_burstcount),
      .avs_read          (avs_read),
      .avs_write         (avs_write),
      .avs_writedata     (avs_writedata),
      .avs_byteenable    (avs_byteenable),
      .avs_waitrequest   (avs_waitrequest),
      .avs_readdata      (avs_readdata),
      .avs_readdatavalid (avs_readdatavalid),
      .busy              (busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   cmd_t   exp_cmd[$];
   cmd_t   obs_cmd[$];
   wbeat_t wsrc[$];
   int     wr_wait_tab[$];

   int   rd_pending, rd_seen, rd_expected, read_hi, wait_hold, wr_beat_idx, wr_total;
   bit   scripted, req_acc, wr_acc_now, wb_active, prev_rdv, prev_rd_wait;
   int   wb_beats;
   t_local_mem_data      prev_rdata;
   t_local_mem_addr      prev_addr, wb_addr;
   t_local_mem_burst_cnt prev_bc, wb_bc;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Observe the bus mid-cycle and feed the memory model.
   task automatic sample();
      @(negedge clk);
      req_acc = req_valid && req_ready;
      if (rd_valid || prev_rdv) begin
         check("rd_valid_latency", rd_valid, prev_rdv);
         if (prev_rdv) check("rd_data", rd_data, prev_rdata);
      end
      if (rd_valid) rd_seen++;
      prev_rdv   = avs_readdatavalid;
      prev_rdata = avs_readdata;

      if (avs_read) begin
         read_hi++;
         if (prev_rd_wait) begin
            check("rd_addr_stable", avs_address, prev_addr);
            check("rd_bc_stable", avs_burstcount, prev_bc);
         end
         if (!avs_waitrequest) begin
            obs_cmd.push_back('{avs_address, avs_burstcount});
            rd_pending += int'(avs_burstcount);
         end
      end
      prev_rd_wait = avs_read && avs_waitrequest;
      prev_addr    = avs_address;
      prev_bc      = avs_burstcount;

      wr_acc_now = wr_valid && wr_ready;
      if (wr_acc_now) check("wr_handshake", avs_write && !avs_waitrequest, 1);
      if (avs_write) begin
         if (!wb_active) begin
            wb_active = 1;
            wb_addr   = avs_address;
            wb_bc     = avs_burstcount;
            wb_beats  = 0;
         end
         check("wr_addr_stable", avs_address, wb_addr);
         check("wr_bc_stable", avs_burstcount, wb_bc);
         if (!avs_waitrequest && wsrc.size() > 0) begin
            check("wr_data", avs_writedata, wsrc[0].data);
            check("wr_byteen", avs_byteenable, wsrc[0].be);
            if (wb_beats == 0) obs_cmd.push_back('{wb_addr, wb_bc});
            wb_beats++;
            if (wb_beats >= int'(wb_bc)) wb_active = 0;
         end
      end
      if ((avs_read || avs_write) && wait_hold > 0) wait_hold--;
   endtask

   // Drive next-cycle inputs just after the active edge.
   task automatic drive();
      @(posedge clk);
      #1;
      if (req_acc) req_valid = 0;
      if (wr_acc_now) begin
         void'(wsrc.pop_front());
         wr_valid = 0;
         wr_total++;
         if (scripted) begin
            wr_beat_idx++;
            wait_hold = (wr_beat_idx < wr_wait_tab.size()) ? wr_wait_tab[wr_beat_idx] : 0;
         end
      end
      if (!wr_valid && wsrc.size() > 0 && (scripted || $urandom_range(0, 3) != 0)) begin
         wr_valid  = 1;
         wr_data   = wsrc[0].data;
         wr_byteen = wsrc[0].be;
      end
      avs_waitrequest = scripted ? (wait_hold > 0) : ($urandom_range(0, 3) == 0);
      if (rd_pending > 0 && (scripted || $urandom_range(0, 2) != 0)) begin
         avs_readdatavalid = 1;
         avs_readdata      = {$urandom, $urandom};
         rd_pending--;
      end else begin
         avs_readdatavalid = 0;
      end
   endtask

   task automatic step();
      sample();
      drive();
   endtask

   task automatic drain();
      int n = 0;
      while ((busy || rd_pending > 0 || !req_ready) && n < LIMIT) begin
         step();
         n++;
      end
      if (n >= LIMIT) check("drain_timeout", 0, 1);
      step();
      step();
   endtask

   task automatic compare_cmds();
      int n;
      check("cmd_count", obs_cmd.size(), exp_cmd.size());
      n = (obs_cmd.size() < exp_cmd.size()) ? obs_cmd.size() : exp_cmd.size();
      for (int i = 0; i < n; i++) begin
         check("cmd_addr", obs_cmd[i].addr, exp_cmd[i].addr);
         check("cmd_bc", obs_cmd[i].bc, exp_cmd[i].bc);
      end
      check("rd_beats", rd_seen, rd_expected);
      check("wr_beats_left", wsrc.size(), 0);
      obs_cmd.delete();
      exp_cmd.delete();
   endtask

   // Expected bursts: walk the range, cutting at every MB-aligned boundary.
   task automatic run_req(input bit rw, input int unsigned a, input int unsigned len, input bit wait_done);
      int unsigned ca, r, b;
      int n;
      ca = a;
      r  = len;
      while (r > 0) begin
         b = MB - (ca % MB);
         if (b > r) b = r;
         exp_cmd.push_back('{t_local_mem_addr'(ca), t_local_mem_burst_cnt'(b)});
         if (!rw) rd_expected += int'(b);
         ca += b;
         r  -= b;
      end
      if (rw) for (int i = 0; i < int'(len); i++) wsrc.push_back('{{$urandom, $urandom}, 8'($urandom)});
      req_rw    = rw;
      req_addr  = t_local_mem_addr'(a);
      req_len   = LW'(len);
      req_valid = 1;
      n = 0;
      while (req_valid && n < LIMIT) begin
         step();
         n++;
      end
      while (!req_ready && n < LIMIT) begin
         step();
         n++;
      end
      if (n >= LIMIT) check("req_timeout", 0, 1);
      if (wait_done) drain();
   endtask

   task automatic start_script(input int hold);
      scripted        = 1;
      wr_beat_idx     = 0;
      wait_hold       = hold;
      avs_waitrequest = (hold > 0);
   endtask

   initial begin
      clk = 0; reset_n = 0;
      req_valid = 0; req_rw = 0; req_addr = '0; req_len = '0;
      wr_valid = 0; wr_data = '0; wr_byteen = '0;
      avs_waitrequest = 0; avs_readdata = '0; avs_readdatavalid = 0;
      rd_pending = 0; rd_seen = 0; rd_expected = 0; read_hi = 0; wait_hold = 0;
      wr_beat_idx = 0; wr_total = 0; scripted = 0; req_acc = 0; wr_acc_now = 0;
      wb_active = 0; wb_beats = 0; prev_rdv = 0; prev_rd_wait = 0;
      prev_rdata = '0; prev_addr = '0; wb_addr = '0; prev_bc = '0; wb_bc = '0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_avs_read", avs_read, 0);
      check("rst_avs_write", avs_write, 0);
      check("rst_busy", busy, 0);
      check("rst_wr_ready", wr_ready, 0);
      check("rst_rd_valid", rd_valid, 0);
      check("rst_address", avs_address, 0);
      check("rst_burstcount", avs_burstcount, 0);
      check("rst_req_ready", req_ready, 1);
      reset_n = 1;
      step();

      // Unaligned read crossing two boundaries.
      run_req(0, 32'h2, 7, 1);
      if (obs_cmd.size() == 3) begin
         check("r7_b0_addr", obs_cmd[0].addr, 32'h2);
         check("r7_b0_bc", obs_cmd[0].bc, 2);
         check("r7_b1_addr", obs_cmd[1].addr, 32'h4);
         check("r7_b2_bc", obs_cmd[2].bc, 1);
      end
      check("r7_busy_done", busy, 0);
      compare_cmds();

      // Zero-length request is a no-op.
      req_rw = 0; req_addr = 32'h8; req_len = '0; req_valid = 1;
      for (int i = 0; i < 4; i++) begin
         step();
         check("len0_req_ready", req_ready, 1);
         check("len0_read", avs_read, 0);
         check("len0_write", avs_write, 0);
         check("len0_busy", busy, 0);
      end
      req_valid = 0;
      compare_cmds();

      // Write burst with stalls on beats 1 and 3.
      wr_wait_tab = '{2, 0, 2, 0};
      start_script(2);
      run_req(1, 32'h0, 4, 1);
      if (obs_cmd.size() == 1) check("w4_bc", obs_cmd[0].bc, 4);
      compare_cmds();

      // Read command held through a long waitrequest.
      wr_wait_tab.delete();
      start_script(5);
      read_hi = 0;
      run_req(0, 32'h10, 4, 1);
      check("rd_hold_cycles", read_hi, 6);
      compare_cmds();

      // Reset in the middle of a write burst.
      wr_wait_tab = '{0, 0, 0, 0};
      start_script(0);
      wr_total = 0;
      req_rw = 1; req_addr = '0; req_len = LW'(4); req_valid = 1;
      for (int i = 0; i < 4; i++) wsrc.push_back('{{$urandom, $urandom}, 8'($urandom)});
      begin
         int n = 0;
         while (wr_total < 1 && n < LIMIT) begin
            step();
            n++;
         end
         if (n >= LIMIT) check("rst_mid_timeout", 0, 1);
      end
      reset_n = 0;
      #1;
      check("mid_rst_avs_read", avs_read, 0);
      check("mid_rst_avs_write", avs_write, 0);
      check("mid_rst_wr_ready", wr_ready, 0);
      check("mid_rst_rd_valid", rd_valid, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_address", avs_address, 0);
      check("mid_rst_burstcount", avs_burstcount, 0);
      wsrc.delete(); obs_cmd.delete(); exp_cmd.delete();
      req_valid = 0; wr_valid = 0; req_acc = 0; wr_acc_now = 0;
      wb_active = 0; rd_pending = 0; prev_rdv = 0; prev_rd_wait = 0;
      avs_readdatavalid = 0; avs_waitrequest = 0;
      rd_seen = 0; rd_expected = 0;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1;
      run_req(0, 32'h0, 1, 1);
      if (obs_cmd.size() == 1) begin
         check("post_rst_addr", obs_cmd[0].addr, 0);
         check("post_rst_bc", obs_cmd[0].bc, 1);
      end
      compare_cmds();

      // Random mix, sometimes overlapping new requests with outstanding reads.
      scripted = 0;
      for (int i = 0; i < 40; i++) begin
         run_req(1'($urandom_range(0, 1)), $urandom_range(0, 40), $urandom_range(0, 11),
                 ($urandom_range(0, 3) == 0));
      end
      drain();
      compare_cmds();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/local_mem_burst_splitter.md
LOCAL_MEM_BURST_SPLITTER -- requirements
Module: local_mem_burst_splitter

Interface
REQ-001 SHALL have parameter MAX_BURST, default 2**(LOCAL_MEM_BURST_CNT_WIDTH-1), the largest Avalon burst issued; it is a power of two.
REQ-002 SHALL have parameter LEN_WIDTH, default 16, the width of the request length in lines.
REQ-003 SHALL use one clock and an asynchronous, active-low reset; both are named below.
REQ-004 SHALL have port `clk`, input, 1 bit: the single clock.
REQ-005 SHALL have port `reset_n`, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have request inputs: `req_valid` (1, input), `req_rw` (1, input, 1 = write), `req_addr` (t_local_mem_addr, input) and `req_len` (LEN_WIDTH, input, length in lines).
REQ-007 SHALL have request output `req_ready` (1, output).
REQ-008 SHALL have write-data inputs `wr_valid` (1), `wr_data` (t_local_mem_data) and `wr_byteen` (t_local_mem_byte_mask), plus output `wr_ready` (1).
REQ-009 SHALL have read-data outputs `rd_valid` (1) and `rd_data` (t_local_mem_data).
REQ-010 SHALL have Avalon outputs `avs_address` (t_local_mem_addr), `avs_burstcount` (t_local_mem_burst_cnt), `avs_read` (1), `avs_write` (1), `avs_writedata` (t_local_mem_data) and `avs_byteenable` (t_local_mem_byte_mask).
REQ-011 SHALL have Avalon inputs `avs_waitrequest` (1), `avs_readdata` (t_local_mem_data) and `avs_readdatavalid` (1).
REQ-012 SHALL have output `busy` (1): high while any command is in progress or any read beat is outstanding.

Function
REQ-013 SHALL implement an FSM with states IDLE, RD_CMD and WR_BEAT.
REQ-014 SHALL assert `req_ready` only in IDLE; a request is accepted when `req_valid` and `req_ready` are both high.
REQ-015 SHALL, on acceptance, latch the address and remaining length, then go to RD_CMD or WR_BEAT according to `req_rw`.
REQ-016 SHALL accept a request with `req_len`=0, stay in IDLE and produce no Avalon traffic.
REQ-017 SHALL compute each burst length as min(remaining, MAX_BURST - (addr mod MAX_BURST)), so no burst crosses a MAX_BURST-aligned boundary.
REQ-018 SHALL, in RD_CMD, assert `avs_read` with a stable address and burstcount until the first cycle in which `avs_waitrequest` is low.
REQ-019 SHALL, on that cycle, add the burst length to the address, subtract it from remaining, and add it to the outstanding-beat counter.
REQ-020 SHALL return to IDLE when remaining reaches 0.
REQ-021 SHALL, in WR_BEAT, drive `avs_write` = `wr_valid` and `wr_ready` = !`avs_waitrequest`.
REQ-022 SHALL pass `wr_data` and `wr_byteen` through combinationally to `avs_writedata` and `avs_byteenable`.
REQ-023 SHALL hold `avs_address` and `avs_burstcount` constant for every beat of a write burst.
REQ-024 SHALL count a write beat when `avs_write` is high and `avs_waitrequest` is low.
REQ-025 SHALL, after the last beat of a write burst, advance the address and remaining length, and return to IDLE when remaining reaches 0.
REQ-026 SHALL drive `wr_ready` low outside WR_BEAT.
REQ-027 SHALL register `avs_readdata`/`avs_readdatavalid` into `rd_data`/`rd_valid` with exactly 1 cycle of latency and no backpressure.
REQ-028 SHALL keep an outstanding-beat counter of width LEN_WIDTH+1 that handles a burst issue and a readdatavalid in the same cycle by adding the burst length and subtracting 1 together.
REQ-029 SHALL hold `busy` = (state != IDLE) || (outstanding != 0).
REQ-030 SHALL accept a new request while reads are still outstanding; ordering is preserved by the memory.

Reset
REQ-031 SHALL, while `reset_n` is low, asynchronously force state to IDLE, clear all counters, and drive `avs_read`, `avs_write`, `rd_valid`, `busy` and `wr_ready` to 0 and the registered address/burstcount to 0.
REQ-032 SHALL abandon any in-flight burst on reset mid-operation; the memory subsystem is reset together with this block.

Structure
REQ-033 SHALL use the types t_local_mem_addr, t_local_mem_data, t_local_mem_burst_cnt and t_local_mem_byte_mask from local_mem_cfg_pkg.
REQ-034 SHALL place the constant LOCAL_MEM_MAX_BURST in that package.
REQ-035 SHALL factor the REQ-017 length computation into the combinational sub-module local_mem_burst_len.

Verification (bench uses MAX_BURST=4, LEN_WIDTH=16)
REQ-036 SHALL cover: read addr 0x2, len 7 -> bursts (0x2,2), (0x4,4), (0x8,1); 7 `rd_valid` pulses, each 1 cycle after its readdatavalid; `busy` drops after the last beat.
REQ-037 SHALL cover: write addr 0x0, len 4 with `avs_waitrequest` high on beats 1 and 3 for 2 cycles each -> one burst (0x0,4), address/burstcount stable, exactly 4 accepted beats in order.
REQ-038 SHALL cover: `req_len`=0 -> `req_ready` stays high, no `avs_read`/`avs_write`, `busy` stays 0.
REQ-039 SHALL cover: read addr 0x10, len 4 with `avs_waitrequest` held 5 cycles -> `avs_read` held 6 cycles with constant command, exactly one burst (0x10,4).
REQ-040 SHALL cover: `reset_n` low at beat 2 of a 4-beat write -> all outputs 0 immediately; after release, a new read addr 0x0, len 1 issues burst (0x0,1) correctly.
